// File: rtl/high_score_tracker.sv
// Per-player and global best-score tracker for the asteroid game.
// Compares each final score to both bests and pulses the LED flags.
module high_score_tracker #(
  parameter int SCORE_W     = 16,
  parameter int NUM_PLAYERS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               GameOver,
  input  logic [SCORE_W-1:0] Score,
  input  logic [1:0]         PlayerID,
  input  logic               ClearBests,
  output logic               NewPersonalBest,
  output logic               NewGlobalBest,
  output logic [SCORE_W-1:0] PersonalBestOut,
  output logic [SCORE_W-1:0] GlobalBestOut,
  output logic               Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    UPDATE  = 2'd2
  } state_e;

  // Slot ids at or above NUM_PLAYERS have no storage behind them.
  localparam logic [2:0] NP_W = 3'(NUM_PLAYERS);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] s_q, s_d;
  logic [1:0]         p_q, p_d;
  logic               pb_hit_q, pb_hit_d;
  logic               gb_hit_q, gb_hit_d;
  logic [SCORE_W-1:0] best_q [4];
  logic [SCORE_W-1:0] best_d [4];
  logic [SCORE_W-1:0] glob_q, glob_d;
  logic               npb_q, npb_d;
  logic               ngb_q, ngb_d;
  logic [SCORE_W-1:0] pbo_q, pbo_d;
  logic               busy_q, busy_d;
  logic               slot_ok;

  assign slot_ok = ({1'b0, PlayerID} < NP_W);

  // Next-state and datapath: latch, compare, then commit the bests.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    p_d      = p_q;
    pb_hit_d = pb_hit_q;
    gb_hit_d = gb_hit_q;
    best_d   = best_q;
    glob_d   = glob_q;
    npb_d    = 1'b0;
    ngb_d    = 1'b0;
    pbo_d    = best_q[PlayerID];
    unique case (state_q)
      IDLE: begin
        if (ClearBests) begin
          for (int i = 0; i < 4; i++)
            best_d[i] = '0;
          glob_d = '0;
        end else if (GameOver && slot_ok) begin
          s_d     = Score;
          p_d     = PlayerID;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        pb_hit_d = (s_q > best_q[p_q]);
        gb_hit_d = (s_q > glob_q);
        state_d  = UPDATE;
      end
      UPDATE: begin
        if (pb_hit_q)
          best_d[p_q] = s_q;
        if (gb_hit_q)
          glob_d = s_q;
        npb_d   = pb_hit_q | gb_hit_q;
        ngb_d   = gb_hit_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any game in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      p_q      <= '0;
      pb_hit_q <= 1'b0;
      gb_hit_q <= 1'b0;
      for (int i = 0; i < 4; i++)
        best_q[i] <= '0;
      glob_q   <= '0;
      npb_q    <= 1'b0;
      ngb_q    <= 1'b0;
      pbo_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      p_q      <= p_d;
      pb_hit_q <= pb_hit_d;
      gb_hit_q <= gb_hit_d;
      best_q   <= best_d;
      glob_q   <= glob_d;
      npb_q    <= npb_d;
      ngb_q    <= ngb_d;
      pbo_q    <= pbo_d;
      busy_q   <= busy_d;
    end
  end

  assign NewPersonalBest = npb_q;
  assign NewGlobalBest   = ngb_q;
  assign PersonalBestOut = pbo_q;
  assign GlobalBestOut   = glob_q;
  assign Busy            = busy_q;

endmodule

// File: tb/tb_high_score_tracker.sv
// Bench for high_score_tracker: scoreboard of expected
// flag pulses and best values, checked per scenario.
module tb_high_score_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        GameOver;
  logic [15:0] Score;
  logic [1:0]  PlayerID;
  logic        ClearBests;
  logic        NewPersonalBest;
  logic        NewGlobalBest;
  logic [15:0] PersonalBestOut;
  logic [15:0] GlobalBestOut;
  logic        Busy;

  typedef struct packed {
    logic        npb;
    logic        ngb;
    logic [15:0] gb;
    logic [15:0] pb;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] m_best [4];
  logic [15:0] m_glob;
  int          checks = 0;
  int          errors = 0;

  high_score_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .GameOver        (GameOver),
    .Score           (Score),
    .PlayerID        (PlayerID),
    .ClearBests      (ClearBests),
    .NewPersonalBest (NewPersonalBest),
    .NewGlobalBest   (NewGlobalBest),
    .PersonalBestOut (PersonalBestOut),
    .GlobalBestOut   (GlobalBestOut),
    .Busy            (Busy)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 4; i++)
      m_best[i] = '0;
    m_glob = '0;
  endtask

  // Drive one GameOver pulse and push the expected outcome.
  task automatic launch(input logic [1:0] pid,
                        input logic [15:0] sc);
    exp_t e;
    @(negedge clk);
    GameOver = 1'b1;
    Score    = sc;
    PlayerID = pid;
    e.ngb = (sc > m_glob);
    e.npb = (sc > m_best[pid]) || e.ngb;
    if (sc > m_best[pid]) m_best[pid] = sc;
    if (e.ngb) m_glob = sc;
    e.gb = m_glob;
    e.pb = m_best[pid];
    sbq.push_back(e);
    @(posedge clk);
    #1 GameOver = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    GameOver   = 1'b0;
    ClearBests = 1'b0;
    Score      = '0;
    PlayerID   = '0;
    model_clear();
    #2;
    checks++;
    if ({NewPersonalBest, NewGlobalBest, Busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000",
               {NewPersonalBest, NewGlobalBest, Busy});
    end
    checks++;
    if ({PersonalBestOut, GlobalBestOut} !== 32'h0) begin
      errors++;
      $display("FAIL reset_bests got %h want 0",
               {PersonalBestOut, GlobalBestOut});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One game: check Busy, flag timing and resulting bests.
  task automatic test_game(input string nm,
                           input logic [1:0] pid,
                           input logic [15:0] sc);
    exp_t e;
    launch(pid, sc);
    e = sbq.pop_front();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (Busy !== (c <= 2)) begin
        errors++;
        $display("FAIL %s busy c%0d got %b want %b",
                 nm, c, Busy, (c <= 2));
      end
      checks++;
      if ({NewPersonalBest, NewGlobalBest} !==
          ((c == 3) ? {e.npb, e.ngb} : 2'b00)) begin
        errors++;
        $display("FAIL %s flags c%0d got %b%b want %b%b",
                 nm, c, NewPersonalBest, NewGlobalBest,
                 (c == 3) & e.npb, (c == 3) & e.ngb);
      end
    end
    checks++;
    if (GlobalBestOut !== e.gb) begin
      errors++;
      $display("FAIL %s global got %h want %h",
               nm, GlobalBestOut, e.gb);
    end
    checks++;
    if (PersonalBestOut !== e.pb) begin
      errors++;
      $display("FAIL %s personal got %h want %h",
               nm, PersonalBestOut, e.pb);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   pulses = 0;
    launch(2'd2, 16'd200);
    e = sbq.pop_front();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (NewPersonalBest | NewGlobalBest) pulses++;
      checks++;
      if ({NewPersonalBest, NewGlobalBest} !==
          ((c == 3) ? {e.npb, e.ngb} : 2'b00)) begin
        errors++;
        $display("FAIL b2b flags c%0d got %b%b",
                 c, NewPersonalBest, NewGlobalBest);
      end
      if (c == 1) begin
        GameOver = 1'b1;
        Score    = 16'd300;
        PlayerID = 2'd3;
      end else if (c == 2) begin
        GameOver = 1'b0;
        PlayerID = 2'd2;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL b2b pulses got %0d want 1", pulses);
    end
    checks++;
    if (GlobalBestOut !== e.gb) begin
      errors++;
      $display("FAIL b2b global got %h want %h",
               GlobalBestOut, e.gb);
    end
    PlayerID = 2'd3;
    @(negedge clk);
    checks++;
    if (PersonalBestOut !== m_best[3]) begin
      errors++;
      $display("FAIL b2b slot3 got %h want %h",
               PersonalBestOut, m_best[3]);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    ClearBests = 1'b1;
    GameOver   = 1'b1;
    Score      = 16'd500;
    PlayerID   = 2'd0;
    model_clear();
    @(posedge clk);
    #1;
    ClearBests = 1'b0;
    GameOver   = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({NewPersonalBest, NewGlobalBest, Busy} !== 3'b000)
      begin
        errors++;
        $display("FAIL clear c%0d got %b want 000", c,
                 {NewPersonalBest, NewGlobalBest, Busy});
      end
    end
    checks++;
    if (GlobalBestOut !== m_glob) begin
      errors++;
      $display("FAIL clear global got %h want %h",
               GlobalBestOut, m_glob);
    end
    checks++;
    if (PersonalBestOut !== m_best[0]) begin
      errors++;
      $display("FAIL clear personal got %h want %h",
               PersonalBestOut, m_best[0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    GameOver = 1'b1;
    Score    = 16'hFFFF;
    PlayerID = 2'd1;
    @(posedge clk);
    #1 GameOver = 1'b0;
    #2 rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({NewPersonalBest, NewGlobalBest, Busy} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid flags got %b want 000",
               {NewPersonalBest, NewGlobalBest, Busy});
    end
    checks++;
    if ({PersonalBestOut, GlobalBestOut} !== 32'h0) begin
      errors++;
      $display("FAIL rstmid bests got %h want 0",
               {PersonalBestOut, GlobalBestOut});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({NewPersonalBest, NewGlobalBest} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid late c%0d got %b%b",
                 c, NewPersonalBest, NewGlobalBest);
      end
    end
    checks++;
    if ({PersonalBestOut, GlobalBestOut} !==
        {m_best[1], m_glob}) begin
      errors++;
      $display("FAIL rstmid after got %h want 0",
               {PersonalBestOut, GlobalBestOut});
    end
  endtask

  initial begin
    test_reset();
    test_game("first", 2'd0, 16'd100);
    test_game("p1", 2'd1, 16'd50);
    test_game("tie", 2'd0, 16'd100);
    test_back_to_back();
    test_clear();
    test_game("zero", 2'd1, 16'd0);
    test_game("max", 2'd3, 16'hFFFF);
    test_game("maxtie", 2'd3, 16'hFFFF);
    test_game("under", 2'd2, 16'd7);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
